// File: rtl/next_pc_unit.sv
// next_pc_unit: registered next-PC target computation with a one-deep
// valid/ready output stage and an optional return-address stack.
// The return-address stack is built only when NEXT_PC_UNIT_RAS_EN is defined.
// Otherwise oRasValid and oRasTarget are tied to zero.

package next_pc_unit_pkg;
  typedef enum logic [2:0] {
    TYPE_OTHER,
    JUMP,
    BRANCH,
    TYPE_LOAD,
    TYPE_STORE,
    TYPE_ALU
  } InstructionTypes;

  typedef enum logic [1:0] {
    SUBTYPE_NONE,
    JUMP_LINK,
    JUMP_LINK_REG
  } InstructionSubTypes;
endpackage

module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iValid,
  output logic                oReady,
  input  InstructionTypes     iInstructionType,
  input  InstructionSubTypes  iInstructionSubType,
  input  logic [XLEN-1:0]     iPC,
  input  logic [XLEN-1:0]     iImmExt,
  input  logic [XLEN-1:0]     iRegOffset,
  input  logic                iIsCall,
  input  logic                iIsReturn,
  input  logic                iFlush,
  output logic                oValid,
  input  logic                iReady,
  output logic [XLEN-1:0]     oPCTarget,
  output logic                oMisaligned,
  output logic [XLEN-1:0]     oRasTarget,
  output logic                oRasValid
);

  // Register-relative jumps drop bit 0 of the sum; all other targets are used as-is.
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] raw,
                                                   input logic            reg_rel);
    align_target = reg_rel ? {raw[XLEN-1:1], 1'b0} : raw;
  endfunction

  // After bit 0 is cleared only bit 1 can break 4-byte alignment of a register-relative target.
  function automatic logic check_misaligned(input logic [XLEN-1:0] raw,
                                            input logic            reg_rel);
    check_misaligned = reg_rel ? raw[1] : (|raw[1:0]);
  endfunction

  logic            reg_rel_p0;
  logic [XLEN-1:0] base_p0;
  logic [XLEN-1:0] raw_p0;
  logic            accept_p0;

  logic            vld_p1;
  logic [XLEN-1:0] target_p1;
  logic            misaligned_p1;

  assign oReady    = !vld_p1 || iReady;
  assign accept_p0 = iValid && oReady && !iFlush;

  // Stage p0: pick the base operand and form the raw target sum.
  always_comb begin
    reg_rel_p0 = (iInstructionType == JUMP) && (iInstructionSubType == JUMP_LINK_REG);
    base_p0    = reg_rel_p0 ? iRegOffset : iPC;
    raw_p0     = base_p0 + iImmExt;
  end

  // Stage p0 -> p1: output register, loads on accept and holds while the consumer stalls.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      vld_p1        <= 1'b0;
      target_p1     <= '0;
      misaligned_p1 <= 1'b0;
    end else if (iFlush) begin
      vld_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1        <= 1'b1;
      target_p1     <= align_target(raw_p0, reg_rel_p0);
      misaligned_p1 <= check_misaligned(raw_p0, reg_rel_p0);
    end else if (iReady) begin
      vld_p1 <= 1'b0;
    end
  end

  assign oValid      = vld_p1;
  assign oPCTarget   = target_p1;
  assign oMisaligned = misaligned_p1;

`ifdef NEXT_PC_UNIT_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [CNT_W-1:0] ras_cnt;
  logic [PTR_W-1:0] ras_ptr_nxt;
  logic [CNT_W-1:0] ras_cnt_nxt;
  logic [PTR_W-1:0] wr_idx;
  logic             wr_en;
  logic [XLEN-1:0]  ret_addr;
  logic             ras_empty;

  assign ret_addr  = iPC + XLEN'(4);
  assign ras_empty = (ras_cnt == '0);

  // Decide push / replace-top / pop for an accepted request; the top pointer marks the newest entry.
  always_comb begin
    ras_ptr_nxt = ras_ptr;
    ras_cnt_nxt = ras_cnt;
    wr_idx      = ras_ptr;
    wr_en       = 1'b0;
    if (accept_p0) begin
      if (iIsCall && iIsReturn && !ras_empty) begin
        wr_en = 1'b1;
      end else if (iIsCall) begin
        wr_en       = 1'b1;
        wr_idx      = ras_ptr + PTR_W'(1);
        ras_ptr_nxt = ras_ptr + PTR_W'(1);
        ras_cnt_nxt = (ras_cnt == CNT_FULL) ? ras_cnt : ras_cnt + CNT_W'(1);
      end else if (iIsReturn && !ras_empty) begin
        ras_ptr_nxt = ras_ptr - PTR_W'(1);
        ras_cnt_nxt = ras_cnt - CNT_W'(1);
      end
    end
  end

  // Stack pointer and occupancy; a full stack wraps onto its oldest entry.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else begin
      ras_ptr <= ras_ptr_nxt;
      ras_cnt <= ras_cnt_nxt;
    end
  end

  // Stack storage is not cleared; reset only blocks writes.
  always_ff @(posedge iClk) begin
    if (iRstN && wr_en) begin
      ras_mem[wr_idx] <= ret_addr;
    end
  end

  assign oRasValid  = !ras_empty;
  assign oRasTarget = ras_empty ? '0 : ras_mem[ras_ptr];
`else
  logic unused_ras_inputs;

  assign unused_ras_inputs = ^{iIsCall, iIsReturn, accept_p0};
  assign oRasValid         = 1'b0;
  assign oRasTarget        = '0;
`endif

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/data width in bits (legal: 32, 64).
REQ-002 SHALL have parameter RAS_DEPTH, default 8, meaning return-address-stack entries (power of two, 2..32).
REQ-003 iClk  input  1  sole clock; all state updates on rising edge.
REQ-004 iRstN  input  1  reset, synchronous, active-low.
REQ-005 iValid  input  1  request present this cycle.
REQ-006 oReady  output  1  unit can accept a request; equals !oValid || iReady.
REQ-007 iInstructionType  input  InstructionTypes  decoded type (JUMP, BRANCH, others).
REQ-008 iInstructionSubType  input  InstructionSubTypes  decoded subtype (JUMP_LINK_REG selects register-relative target).
REQ-009 iPC, iImmExt, iRegOffset  input  XLEN each  current PC, sign-extended immediate, rs1 value.
REQ-010 iIsCall, iIsReturn  input  1 each  request is a call (push) / return (pop); ignored unless accepted.
REQ-011 iFlush  input  1  discard in-flight result and same-cycle request.
REQ-012 oValid  output  1  oPCTarget/oMisaligned hold a result.
REQ-013 iReady  input  1  consumer takes the result this cycle.
REQ-014 oPCTarget  output  XLEN  registered target address.
REQ-015 oMisaligned  output  1  registered flag: target not 4-byte aligned.
REQ-016 oRasTarget  output  XLEN  current top-of-stack return address.
REQ-017 oRasValid  output  1  stack non-empty.

Function
REQ-018 Request accepted when iValid && oReady && !iFlush; result appears on oPCTarget/oValid the following cycle (latency 1).
REQ-019 JUMP with JUMP_LINK_REG: raw = iImmExt + iRegOffset mod 2^XLEN; oPCTarget = raw with bit0 cleared; oMisaligned = raw[1].
REQ-020 All other types: oPCTarget = iPC + iImmExt mod 2^XLEN; oMisaligned = |oPCTarget[1:0].
REQ-021 oValid, oPCTarget, oMisaligned SHALL hold unchanged while oValid && !iReady (no new accept).
REQ-022 oValid clears on iReady with no accept; accept with iReady high in same cycle replaces result back-to-back without a bubble.
REQ-023 iFlush: oValid = 0 next cycle; same-cycle request discarded, including its stack effect; stack contents untouched.
REQ-024 Stack is circular, pointer log2(RAS_DEPTH) bits, count 0..RAS_DEPTH.
REQ-025 Accepted call only: push iPC+4 (mod 2^XLEN); at count = RAS_DEPTH overwrite oldest entry, count saturates.
REQ-026 Accepted return only: pop; at count = 0 no change, pointer does not move.
REQ-027 Accepted call and return together: top entry replaced by iPC+4, count unchanged (count 0 -> behaves as push).
REQ-028 oRasTarget = entry at top pointer, valid next cycle after push/pop; oRasValid = (count != 0); oRasTarget = 0 when count = 0.

Reset
REQ-029 With iRstN low at a rising edge: oValid = 0, oPCTarget = 0, oMisaligned = 0, count = 0, pointer = 0, oRasValid = 0, oRasTarget = 0.
REQ-030 Reset SHALL override iValid, iFlush and in-flight results; stack entry contents need not be cleared.

Configuration
REQ-031 Macro NEXT_PC_UNIT_RAS_EN: defined -> return-address stack built per REQ-024..028.
REQ-032 Undefined -> no stack storage, iIsCall/iIsReturn ignored, oRasValid = 0 and oRasTarget = 0 permanently; target path unchanged.

Verification
REQ-033 BRANCH, iPC=0x1000, iImmExt=0xFFFFFFF8, XLEN=32 -> next cycle oPCTarget=0x00000FF8, oMisaligned=0, oValid=1.
REQ-034 JUMP/JUMP_LINK_REG, iRegOffset=0x2003, iImmExt=0 -> oPCTarget=0x2002, oMisaligned=1.
REQ-035 Hold iReady=0 for 3 cycles after accept, then iReady=1 with new iValid -> result stable for 3 cycles, then replaced next cycle with no bubble.
REQ-036 RAS_DEPTH=8, 9 calls at iPC=0x100,0x200..0x900, then 9 returns -> tops read 0x904,0x804..0x204, then oRasValid=0; 9th pop no-op.
REQ-037 Call+return together at iPC=0x40 with top 0x104 -> top becomes 0x44, count unchanged.
REQ-038 iFlush with accepted-looking call, then iRstN low mid-stream -> no push, oValid=0; after reset all outputs 0.
